// File: rtl/f_pc_npc_pkg.sv
// Shared fetch-stage definitions: next-PC opcodes used by the D-stage
// controller and this unit, plus the reset PC and instruction memory window.
package f_pc_npc_pkg;

   typedef enum logic [2:0] {
      NPC_SEQ  = 3'd0,
      NPC_BEQ  = 3'd1,
      NPC_BNE  = 3'd2,
      NPC_J    = 3'd3,
      NPC_JR   = 3'd4,
      NPC_CJAL = 3'd5
   } npc_op_e;

   localparam logic [31:0] RESET_PC = 32'h0000_3000;
   localparam logic [31:0] IM_BASE  = 32'h0000_3000;
   localparam int          IM_DEPTH = 4096;
   // First byte address past the instruction memory
   localparam logic [31:0] IM_LIMIT = IM_BASE + 32'(4 * IM_DEPTH);

   // Word aligned and inside [IM_BASE, IM_LIMIT)
   function automatic logic fetch_legal(input logic [31:0] addr);
      return (addr[1:0] == 2'b00) && (addr >= IM_BASE) && (addr < IM_LIMIT);
   endfunction

endpackage

// File: rtl/f_pc_npc_sel.sv
// Combinational target and redirect selection for the D-stage control
// transfer. The fall-through address is F_PC + 4: the instruction already in
// F is the delay slot, so D_PC + 4 is never a candidate.
module npc_sel
   import f_pc_npc_pkg::*;
(
   input  logic [2:0]  op_i,
   input  logic [31:0] d_pc_i,
   input  logic [15:0] imm16_i,
   input  logic [25:0] imm26_i,
   input  logic [31:0] rd1_i,
   input  logic        zero_i,
   input  logic        flag_jal_i,
   input  logic [31:0] f_pc_i,
   output logic        redirect_o,
   output logic [31:0] npc_o,
   output logic [31:0] pc8_o
);

   logic [31:0] br_tgt;
   logic [31:0] j_tgt;
   logic [31:0] tgt;

   assign br_tgt = d_pc_i + 32'd4 + {{14{imm16_i[15]}}, imm16_i, 2'b00};
   assign j_tgt  = {d_pc_i[31:28], imm26_i, 2'b00};
   assign pc8_o  = d_pc_i + 32'd8;

   // Decode the redirect condition and its target; codes 6-7 fall through
   always_comb begin
      redirect_o = 1'b0;
      tgt        = br_tgt;
      case (op_i)
         NPC_BEQ:  redirect_o = zero_i;
         NPC_BNE:  redirect_o = ~zero_i;
         NPC_J: begin
            redirect_o = 1'b1;
            tgt        = j_tgt;
         end
         NPC_JR: begin
            redirect_o = 1'b1;
            tgt        = rd1_i;
         end
         NPC_CJAL: begin
            redirect_o = flag_jal_i;
            tgt        = j_tgt;
         end
         default:  redirect_o = 1'b0;
      endcase
   end

   assign npc_o = redirect_o ? tgt : (f_pc_i + 32'd4);

endmodule

// File: rtl/f_pc_npc.sv
// Fetch PC register and next-PC unit with one delay slot, a saturating
// redirect counter and an optional fetch range check enabled by the macro
// F_PC_RANGE_CHECK_EN (sticky F_PCErr, illegal NPC not loaded).
module f_pc_npc
   import f_pc_npc_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        F_Stall,
   input  logic [2:0]  D_NPCOp,
   input  logic [31:0] D_PC,
   input  logic [15:0] D_Imm16,
   input  logic [25:0] D_Imm26,
   input  logic [31:0] D_RD1,
   input  logic        D_Zero,
   input  logic        D_FlagJAL,
   output logic [31:0] F_PC,
   output logic        D_Redirect,
   output logic [31:0] D_PC8,
   output logic [15:0] F_RedirCnt,
   output logic        F_PCErr
);

   logic [31:0] npc;
   logic        npc_ok;
   logic        load;
   logic [31:0] pc_q, pc_d;
   logic [15:0] cnt_q, cnt_d;

   npc_sel u_sel (
      .op_i       (D_NPCOp),
      .d_pc_i     (D_PC),
      .imm16_i    (D_Imm16),
      .imm26_i    (D_Imm26),
      .rd1_i      (D_RD1),
      .zero_i     (D_Zero),
      .flag_jal_i (D_FlagJAL),
      .f_pc_i     (pc_q),
      .redirect_o (D_Redirect),
      .npc_o      (npc),
      .pc8_o      (D_PC8)
   );

`ifdef F_PC_RANGE_CHECK_EN
   logic err_q, err_d;

   assign npc_ok = fetch_legal(npc);

   // Sticky error: set by any unstalled attempt to fetch outside the window
   always_comb begin
      err_d = err_q | (~F_Stall & ~npc_ok);
   end

   // Error flag register, cleared only by reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) err_q <= 1'b0;
      else       err_q <= err_d;
   end

   assign F_PCErr = err_q;
`else
   assign npc_ok  = 1'b1;
   assign F_PCErr = 1'b0;
`endif

   // Stall wins over redirect; a rejected NPC also holds PC and the count
   assign load = ~F_Stall & npc_ok;

   // Next-state for PC and the saturating redirect counter
   always_comb begin
      pc_d  = pc_q;
      cnt_d = cnt_q;
      if (load) begin
         pc_d = npc;
         if (D_Redirect && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
      end
   end

   // PC and counter registers with asynchronous reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q  <= RESET_PC;
         cnt_q <= 16'd0;
      end else begin
         pc_q  <= pc_d;
         cnt_q <= cnt_d;
      end
   end

   assign F_PC       = pc_q;
   assign F_RedirCnt = cnt_q;

endmodule

// File: tb/tb_f_pc_npc.sv
// Self-checking bench for f_pc_npc: reset, directed vector table, range-check
// corner, reset during stall, randomized run against a reference model, and
// counter saturation.
module tb_f_pc_npc;

   logic        clk = 1'b0;
   logic        reset;
   logic        F_Stall;
   logic [2:0]  D_NPCOp;
   logic [31:0] D_PC;
   logic [15:0] D_Imm16;
   logic [25:0] D_Imm26;
   logic [31:0] D_RD1;
   logic        D_Zero;
   logic        D_FlagJAL;
   logic [31:0] F_PC;
   logic        D_Redirect;
   logic [31:0] D_PC8;
   logic [15:0] F_RedirCnt;
   logic        F_PCErr;

   int n_chk  = 0;
   int n_fail = 0;

   f_pc_npc dut (
      .clk        (clk),
      .reset      (reset),
      .F_Stall    (F_Stall),
      .D_NPCOp    (D_NPCOp),
      .D_PC       (D_PC),
      .D_Imm16    (D_Imm16),
      .D_Imm26    (D_Imm26),
      .D_RD1      (D_RD1),
      .D_Zero     (D_Zero),
      .D_FlagJAL  (D_FlagJAL),
      .F_PC       (F_PC),
      .D_Redirect (D_Redirect),
      .D_PC8      (D_PC8),
      .F_RedirCnt (F_RedirCnt),
      .F_PCErr    (F_PCErr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] dpc;
      logic [15:0] imm16;
      logic [25:0] imm26;
      logic [31:0] rd1;
      logic        zero;
      logic        flag;
      logic        stall;
      logic        redir;
      logic [31:0] pc8;
      logic [31:0] fpc;
      logic [15:0] cnt;
   } vec_t;

   vec_t tbl [14];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic [2:0] op, input logic [31:0] dpc, input logic [15:0] i16,
                        input logic [25:0] i26, input logic [31:0] rd1, input logic z,
                        input logic f, input logic st);
      D_NPCOp = op; D_PC = dpc; D_Imm16 = i16; D_Imm26 = i26;
      D_RD1 = rd1; D_Zero = z; D_FlagJAL = f; F_Stall = st;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: architectural rules in plain arithmetic
   task automatic ref_eval(input int op, input logic [31:0] dpc, input logic [15:0] i16,
                           input logic [25:0] i26, input logic [31:0] rd1, input bit z,
                           input bit f, output bit redir, output logic [31:0] tgt);
      int signed off;
      off   = $signed(i16) * 4;
      redir = 0;
      tgt   = 32'h0;
      if (op == 1 && z)       begin redir = 1; tgt = dpc + 32'd4 + 32'(off); end
      else if (op == 2 && !z) begin redir = 1; tgt = dpc + 32'd4 + 32'(off); end
      else if (op == 3)       begin redir = 1; tgt = (dpc & 32'hF000_0000) + ({6'd0, i26} * 4); end
      else if (op == 4)       begin redir = 1; tgt = rd1; end
      else if (op == 5 && f)  begin redir = 1; tgt = (dpc & 32'hF000_0000) + ({6'd0, i26} * 4); end
   endtask

   logic [31:0] m_pc;
   int          m_cnt;
   bit          m_err;

   initial begin
      drive(3'd0, 32'h3000, 16'h0, 26'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      reset = 1'b1;
      #1;
      chk("reset_fpc", F_PC, 32'h3000);
      chk("reset_cnt", {16'h0, F_RedirCnt}, 32'h0);
      chk("reset_err", {31'h0, F_PCErr}, 32'h0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      repeat (4) tick();
      chk("seq_to_3010", F_PC, 32'h3010);
      // Asynchronous reset mid-cycle
      #2 reset = 1'b1;
      #1 chk("async_reset_fpc", F_PC, 32'h3000);
      tick();
      reset = 1'b0;
      tick();
      chk("seq_3004", F_PC, 32'h3004);
      tick();
      chk("seq_3008", F_PC, 32'h3008);

      // Directed vector table starting from F_PC = 0x3008, count 0
      tbl[0]  = '{3'd0, 32'h3004, 16'h0000, 26'h0,    32'h0,    1'b0, 1'b0, 1'b0, 1'b0, 32'h300C, 32'h300C, 16'd0};
      tbl[1]  = '{3'd1, 32'h3008, 16'hFFFE, 26'h0,    32'h0,    1'b1, 1'b0, 1'b0, 1'b1, 32'h3010, 32'h3004, 16'd1};
      tbl[2]  = '{3'd1, 32'h3008, 16'hFFFE, 26'h0,    32'h0,    1'b0, 1'b0, 1'b0, 1'b0, 32'h3010, 32'h3008, 16'd1};
      tbl[3]  = '{3'd2, 32'h3100, 16'h0010, 26'h0,    32'h0,    1'b0, 1'b0, 1'b0, 1'b1, 32'h3108, 32'h3144, 16'd2};
      tbl[4]  = '{3'd2, 32'h3100, 16'h0010, 26'h0,    32'h0,    1'b1, 1'b0, 1'b0, 1'b0, 32'h3108, 32'h3148, 16'd2};
      tbl[5]  = '{3'd3, 32'h3000, 16'h0000, 26'h0C80, 32'h0,    1'b0, 1'b0, 1'b0, 1'b1, 32'h3008, 32'h3200, 16'd3};
      tbl[6]  = '{3'd4, 32'h3200, 16'h0000, 26'h0,    32'h3400, 1'b0, 1'b0, 1'b1, 1'b1, 32'h3208, 32'h3200, 16'd3};
      tbl[7]  = '{3'd4, 32'h3200, 16'h0000, 26'h0,    32'h3400, 1'b0, 1'b0, 1'b1, 1'b1, 32'h3208, 32'h3200, 16'd3};
      tbl[8]  = '{3'd4, 32'h3200, 16'h0000, 26'h0,    32'h3400, 1'b0, 1'b0, 1'b0, 1'b1, 32'h3208, 32'h3400, 16'd4};
      tbl[9]  = '{3'd5, 32'h3020, 16'h0000, 26'h0C40, 32'h0,    1'b0, 1'b1, 1'b0, 1'b1, 32'h3028, 32'h3100, 16'd5};
      tbl[10] = '{3'd5, 32'h3020, 16'h0000, 26'h0C40, 32'h0,    1'b0, 1'b0, 1'b0, 1'b0, 32'h3028, 32'h3104, 16'd5};
      tbl[11] = '{3'd6, 32'h3104, 16'hFFFE, 26'h0C40, 32'h3400, 1'b1, 1'b1, 1'b0, 1'b0, 32'h310C, 32'h3108, 16'd5};
      tbl[12] = '{3'd7, 32'hFFFF_FFFC, 16'hFFFE, 26'h0C40, 32'h3400, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0004, 32'h310C, 16'd5};
      tbl[13] = '{3'd0, 32'h3108, 16'h0000, 26'h0,    32'h0,    1'b0, 1'b0, 1'b1, 1'b0, 32'h3110, 32'h310C, 16'd5};

      for (int i = 0; i < 14; i++) begin
         drive(tbl[i].op, tbl[i].dpc, tbl[i].imm16, tbl[i].imm26, tbl[i].rd1,
               tbl[i].zero, tbl[i].flag, tbl[i].stall);
         #1;
         chk($sformatf("vec%0d_redirect", i), {31'h0, D_Redirect}, {31'h0, tbl[i].redir});
         chk($sformatf("vec%0d_pc8", i), D_PC8, tbl[i].pc8);
         tick();
         chk($sformatf("vec%0d_fpc", i), F_PC, tbl[i].fpc);
         chk($sformatf("vec%0d_cnt", i), {16'h0, F_RedirCnt}, {16'h0, tbl[i].cnt});
      end

      // Misaligned JR target, then a legal jump
      drive(3'd4, 32'h3108, 16'h0, 26'h0, 32'h3002, 1'b0, 1'b0, 1'b0);
      tick();
`ifdef F_PC_RANGE_CHECK_EN
      chk("bad_jr_fpc", F_PC, 32'h310C);
      chk("bad_jr_err", {31'h0, F_PCErr}, 32'h1);
      chk("bad_jr_cnt", {16'h0, F_RedirCnt}, 32'd5);
`else
      chk("bad_jr_fpc", F_PC, 32'h3002);
      chk("bad_jr_err", {31'h0, F_PCErr}, 32'h0);
      chk("bad_jr_cnt", {16'h0, F_RedirCnt}, 32'd6);
`endif
      drive(3'd3, 32'h3000, 16'h0, 26'h0C80, 32'h0, 1'b0, 1'b0, 1'b0);
      tick();
      chk("after_bad_fpc", F_PC, 32'h3200);
`ifdef F_PC_RANGE_CHECK_EN
      chk("err_sticky", {31'h0, F_PCErr}, 32'h1);
      chk("after_bad_cnt", {16'h0, F_RedirCnt}, 32'd6);
`else
      chk("err_tied", {31'h0, F_PCErr}, 32'h0);
      chk("after_bad_cnt", {16'h0, F_RedirCnt}, 32'd7);
`endif

      // Reset while a stalled JR sits in D
      drive(3'd4, 32'h3200, 16'h0, 26'h0, 32'h3400, 1'b0, 1'b0, 1'b1);
      #2 reset = 1'b1;
      #1;
      chk("stall_reset_fpc", F_PC, 32'h3000);
      chk("stall_reset_cnt", {16'h0, F_RedirCnt}, 32'h0);
      chk("stall_reset_err", {31'h0, F_PCErr}, 32'h0);
      tick();
      reset = 1'b0;
      m_pc = 32'h3000; m_cnt = 0; m_err = 0;

      // Randomized run against the reference model
      for (int n = 0; n < 400; n++) begin
         int          op;
         logic [31:0] dpc, rd1, tgt, npc;
         logic [15:0] i16;
         logic [25:0] i26;
         bit          z, f, st, redir, legal;
         op  = int'($urandom_range(0, 7));
         dpc = ($urandom_range(0, 7) == 0) ? $urandom : (32'h3000 + 32'($urandom_range(0, 4095)) * 4);
         i16 = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($signed(8'($urandom)));
         i26 = ($urandom_range(0, 7) == 0) ? 26'($urandom) : 26'($urandom_range(32'hC00, 32'h1BFF));
         rd1 = ($urandom_range(0, 7) == 0) ? $urandom : (32'h3000 + 32'($urandom_range(0, 4095)) * 4);
         z   = 1'($urandom); f = 1'($urandom);
         st  = ($urandom_range(0, 3) == 0);
         drive(3'(op), dpc, i16, i26, rd1, z, f, st);
         ref_eval(op, dpc, i16, i26, rd1, z, f, redir, tgt);
         #1;
         chk("rnd_redirect", {31'h0, D_Redirect}, {31'h0, redir});
         chk("rnd_pc8", D_PC8, dpc + 32'd8);
         npc   = redir ? tgt : m_pc + 32'd4;
`ifdef F_PC_RANGE_CHECK_EN
         legal = (npc % 4 == 0) && (npc >= 32'h3000) && (npc < 32'h7000);
`else
         legal = 1;
`endif
         if (!st) begin
            if (legal) begin
               m_pc = npc;
               if (redir && m_cnt < 65535) m_cnt++;
            end else m_err = 1;
         end
         tick();
         chk("rnd_fpc", F_PC, m_pc);
         chk("rnd_cnt", {16'h0, F_RedirCnt}, 32'(m_cnt));
         chk("rnd_err", {31'h0, F_PCErr}, {31'h0, m_err});
      end

      // Counter saturation: jump-to-self every cycle
      reset = 1'b1;
      #1 reset = 1'b0;
      drive(3'd3, 32'h3000, 16'h0, 26'h0C00, 32'h0, 1'b0, 1'b0, 1'b0);
      repeat (65534) @(posedge clk);
      #1;
      chk("sat_preload", {16'h0, F_RedirCnt}, 32'h0000_FFFE);
      repeat (3) @(posedge clk);
      #1;
      chk("sat_hold", {16'h0, F_RedirCnt}, 32'h0000_FFFF);
      chk("sat_fpc", F_PC, 32'h3000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/f_pc_npc.md
# f_pc_npc

Fetch-stage program counter and next-PC unit for the five-stage MIPS pipeline. Consumes the D-stage branch comparison results (`D_Zero` for beq/bne, `D_FlagJAL` for the parity-conditional jal), the forwarded rs value and the decoded immediates, then selects and registers the next fetch address with one architectural delay slot. Sits between the D-stage compare/decode logic and the instruction memory address port. Also keeps a saturating redirect counter for the performance report.

## Interface
- `RESET_PC`, 32'h0000_3000: fetch address after reset.
- `IM_BASE`, 32'h0000_3000: first valid instruction byte address.
- `IM_DEPTH`, 4096: instruction memory size in words.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high.
- `F_Stall` input 1: hold PC; same stall that freezes the F/D register.
- `D_NPCOp` input 3: 0 SEQ, 1 BEQ, 2 BNE, 3 J (j/jal), 4 JR (jr/jalr), 5 CJAL; 6–7 treated as SEQ.
- `D_PC` input 32: PC of the instruction in D.
- `D_Imm16` input 16: branch offset.
- `D_Imm26` input 26: jump index.
- `D_RD1` input 32: forwarded rs.
- `D_Zero` input 1: rs == rt.
- `D_FlagJAL` input 1: rs has even parity.
- `F_PC` output 32: registered fetch address.
- `D_Redirect` output 1: the D-stage instruction redirects fetch this cycle.
- `D_PC8` output 32: link address, `D_PC + 8`.
- `F_RedirCnt` output 16: saturating count of committed redirects.
- `F_PCErr` output 1: sticky illegal-fetch flag.

## Operation
- Branch target: `D_PC + 4 + (sext(D_Imm16) << 2)`. Jump target: `{D_PC[31:28], D_Imm26, 2'b00}`. JR target: `D_RD1`.
- Redirect conditions:
  - BEQ redirects when `D_Zero = 1`.
  - BNE redirects when `D_Zero = 0`.
  - J and JR always redirect.
  - CJAL redirects to the jump target when `D_FlagJAL = 1`.
  - Otherwise no redirect.
- `D_Redirect` is combinational from the conditions above.
- NPC is the selected target when `D_Redirect = 1`, else `F_PC + 4`. It is never `D_PC + 4`: the delay slot is the instruction already in F.
- PC register:
  - Loads NPC on each rising edge when `F_Stall = 0`.
  - Holds when `F_Stall = 1`. The branch also holds in D and is re-evaluated with fresh forwarded operands next cycle.
- `F_RedirCnt` increments on edges where `D_Redirect & ~F_Stall`. Saturates at 0xFFFF. Stalled cycles never count.
- All arithmetic is modulo 2^32. Wrap-around of `F_PC + 4` is not special-cased.

## Timing
- Reset values: `F_PC = RESET_PC`, `F_RedirCnt = 0`, `F_PCErr = 0`.
- `reset` forces these values immediately, independent of `clk`, including mid-stall or mid-redirect.
- First post-reset fetch: `RESET_PC`. First load happens on the first edge after `reset` deasserts.
- Redirect latency: the target appears on `F_PC` one cycle after the branch sits unstalled in D. Exactly one delay-slot instruction is fetched.
- `D_Redirect` and `D_PC8` are combinational, with zero latency.
- Stall and redirect together: stall wins. PC holds, no count.

## Configuration
- `F_PC_RANGE_CHECK_EN` defined:
  - An NPC is illegal when it is not word aligned, below `IM_BASE`, or at or above `IM_BASE + 4*IM_DEPTH`.
  - An illegal NPC on an unstalled edge is not loaded. PC holds and `F_PCErr` sets.
  - `F_PCErr` stays set until `reset`.
  - Holding PC also suppresses the count.
- Not defined: no check is performed, the illegal NPC loads, and `F_PCErr` is tied 0.

## Structure
- Shared package: NPCOp encodings (`NPC_SEQ`, `NPC_BEQ`, `NPC_BNE`, `NPC_J`, `NPC_JR`, `NPC_CJAL`) and the `RESET_PC` constant. The D-stage controller uses the same encodings.
- One sub-module: `npc_sel`, a combinational target/redirect selection. The top level holds the PC register, the counter and the range check.

## Test plan
- Reset and sequential fetch: assert `reset` mid-cycle with `F_PC = 0x3010`; it reads 0x3000 immediately. Release `reset` with SEQ → 0x3004, 0x3008.
- Branch taken and not taken:
  - BEQ, `D_PC = 0x3008`, imm16 = 0xFFFE, `D_Zero = 1`, `F_PC = 0x300C` → next `F_PC = 0x3004`, `F_RedirCnt = 1`.
  - Same with `D_Zero = 0` → 0x3010, count unchanged.
- JR with stall: `D_RD1 = 0x3100`, `F_Stall = 1` for 2 cycles → `F_PC` holds and the count is unchanged. Release the stall → 0x3100 and count +1.
- CJAL: `D_FlagJAL = 1`, `D_PC = 0x3020`, imm26 = 0x0C40 → 0x3100 and `D_PC8 = 0x3028`. With `D_FlagJAL = 0` → `F_PC + 4`.
- Counter saturation: preload 0xFFFE via 2^16−2 redirects, then apply 3 more → reads 0xFFFF.
- With `F_PC_RANGE_CHECK_EN`: JR to 0x3002 → `F_PC` holds and `F_PCErr = 1`. `F_PCErr` stays 1 after subsequent legal redirects until `reset`. Without the macro → `F_PC = 0x3002` and `F_PCErr = 0`.
